// File: rtl/led_frame_pkg.sv
// Shared constants and types for the LED frame decoder.
// LED_FRAME_CHECKSUM_EN adds the CHECK state (trailing XOR checksum byte).
package led_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef LED_FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, COUNT, PAYLOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, COUNT, PAYLOAD} state_t;
`endif

  typedef logic [7:0] bright_t;
  typedef logic [7:0] count_t;

endpackage

// File: rtl/led_bank_ram.sv
// Double-buffered brightness store: two banks of LED_COUNT bytes, one write
// port and one registered read port, each selecting its own bank.
module led_bank_ram
  import led_frame_pkg::*;
#(
  parameter int LED_COUNT = 16
) (
  input  logic    clock_uart,
  input  logic    we,
  input  logic    wr_bank,
  input  count_t  wr_idx,
  input  bright_t wr_data,
  input  logic    rd_bank,
  input  count_t  rd_idx,
  output bright_t rd_q
);

  localparam int DEPTH = 2 * LED_COUNT;
  localparam int AW    = $clog2(DEPTH);

  bright_t       mem [DEPTH];
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // Bank 1 occupies the upper LED_COUNT entries of the flat array.
  assign wr_addr = wr_bank ? AW'(LED_COUNT) + AW'(wr_idx) : AW'(wr_idx);
  assign rd_addr = rd_bank ? AW'(LED_COUNT) + AW'(rd_idx) : AW'(rd_idx);

  always_ff @(posedge clock_uart) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/led_frame_decoder.sv
// Decodes sync/count/payload LED frames into the back bank and swaps banks on
// a complete frame. LED_FRAME_CHECKSUM_EN enables the trailing XOR checksum.
module led_frame_decoder
  import led_frame_pkg::*;
#(
  parameter int LED_COUNT      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clock_uart,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_data_ready,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] active_count,
  output logic       frame_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam count_t         LED_MAX = count_t'(LED_COUNT);

  state_t        state_q, state_d;
  count_t        count_q, count_d;
  count_t        index_q, index_d;
  count_t        active_count_q, active_count_d;
  logic          bank_q, bank_d;
  logic          frame_valid_q, frame_valid_d;
  logic          frame_error_q, frame_error_d;
  logic          busy_q;
  logic          in_range_q, in_range_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ram_we;
  count_t        rd_idx;
  bright_t       ram_rd;
`ifdef LED_FRAME_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    index_d        = index_q;
    active_count_d = active_count_q;
    bank_d         = bank_q;
    frame_valid_d  = 1'b0;
    frame_error_d  = 1'b0;
    timer_d        = timer_q;
    ram_we         = 1'b0;
`ifdef LED_FRAME_CHECKSUM_EN
    csum_d         = csum_q;
`endif
    if (rx_data_ready) begin
      timer_d = '0;
      case (state_q)
        IDLE: begin
          if (rx_data == SYNC_BYTE) state_d = COUNT;
        end
        COUNT: begin
          if (rx_data != 8'd0 && rx_data <= LED_MAX) begin
            count_d = rx_data;
            index_d = 8'd0;
`ifdef LED_FRAME_CHECKSUM_EN
            csum_d  = rx_data;
`endif
            state_d = PAYLOAD;
          end else begin
            frame_error_d = 1'b1;
            state_d       = IDLE;
          end
        end
        PAYLOAD: begin
          ram_we = 1'b1;
`ifdef LED_FRAME_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (index_q == count_q - 8'd1) begin
`ifdef LED_FRAME_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d        = IDLE;
            bank_d         = ~bank_q;
            active_count_d = count_q;
            frame_valid_d  = 1'b1;
`endif
          end else begin
            index_d = index_q + 8'd1;
          end
        end
`ifdef LED_FRAME_CHECKSUM_EN
        CHECK: begin
          state_d = IDLE;
          if (rx_data == csum_q) begin
            bank_d         = ~bank_q;
            active_count_d = count_q;
            frame_valid_d  = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      timer_d = '0;
    end else if (timer_q == TO_LAST) begin
      // Inter-byte gap exceeded: drop the frame; the back bank stays dirty.
      frame_error_d = 1'b1;
      state_d       = IDLE;
      timer_d       = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Out-of-range reads are steered to entry 0 and masked to zero on output.
  assign in_range_d = (rd_addr < active_count_q);
  assign rd_idx     = in_range_d ? rd_addr : 8'd0;

  always_ff @(posedge clock_uart) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= 8'd0;
      index_q        <= 8'd0;
      active_count_q <= 8'd0;
      bank_q         <= 1'b0;
      frame_valid_q  <= 1'b0;
      frame_error_q  <= 1'b0;
      busy_q         <= 1'b0;
      in_range_q     <= 1'b0;
      timer_q        <= '0;
`ifdef LED_FRAME_CHECKSUM_EN
      csum_q         <= 8'd0;
`endif
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      index_q        <= index_d;
      active_count_q <= active_count_d;
      bank_q         <= bank_d;
      frame_valid_q  <= frame_valid_d;
      frame_error_q  <= frame_error_d;
      busy_q         <= (state_d != IDLE);
      in_range_q     <= in_range_d;
      timer_q        <= timer_d;
`ifdef LED_FRAME_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

  led_bank_ram #(
    .LED_COUNT(LED_COUNT)
  ) u_bank_ram (
    .clock_uart(clock_uart),
    .we        (ram_we),
    .wr_bank   (~bank_q),
    .wr_idx    (index_q),
    .wr_data   (rx_data),
    .rd_bank   (bank_q),
    .rd_idx    (rd_idx),
    .rd_q      (ram_rd)
  );

  assign rd_data      = in_range_q ? ram_rd : 8'd0;
  assign active_count = active_count_q;
  assign frame_valid  = frame_valid_q;
  assign frame_error  = frame_error_q;
  assign busy         = busy_q;

endmodule
